// File: rtl/conv2_weight_loader_pkg.sv
// Shared types for the conv2 weight loader: default geometry and the loader FSM state encoding.
package conv2_weight_loader_pkg;

  localparam int unsigned ST2_CONV_CO_DEF = 3;
  localparam int unsigned ST2_CONV_CI_DEF = 3;
  localparam int unsigned KX_DEF          = 5;
  localparam int unsigned KY_DEF          = 5;
  localparam int unsigned ST2_W_BW_DEF    = 8;
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int unsigned total_weights(input int unsigned co, input int unsigned ci,
                                                input int unsigned kx, input int unsigned ky);
    return co * ci * kx * ky;
  endfunction

endpackage

// File: rtl/conv2_weight_loader_regfile.sv
// Weight storage: one write port, every entry exposed on a flattened read bus.
module conv2_weight_regfile
  import conv2_weight_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 225,
  parameter int unsigned DW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [CNT_W-1:0]      wr_addr,
  input  logic [DW-1:0]         wr_data,
  output logic [DEPTH*DW-1:0]   rd_bus
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_bus = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_bus[i*DW +: DW] = mem_q[i];
    end
  end

endmodule

// File: rtl/conv2_weight_loader.sv
// Streams a full conv2 kernel set into registered storage and flags when the bus is complete.
module conv2_weight_loader
  import conv2_weight_loader_pkg::*;
#(
  parameter int unsigned ST2_Conv_CO = ST2_CONV_CO_DEF,
  parameter int unsigned ST2_Conv_CI = ST2_CONV_CI_DEF,
  parameter int unsigned KX          = KX_DEF,
  parameter int unsigned KY          = KY_DEF,
  parameter int unsigned ST2_W_BW    = ST2_W_BW_DEF,
  localparam int unsigned TOTAL_WEIGHT = total_weights(ST2_Conv_CO, ST2_Conv_CI, KX, KY)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic signed [ST2_W_BW-1:0]              s_data,
  input  logic                                    s_valid,
  input  logic                                    s_last,
  output logic                                    s_ready,
  output logic signed [TOTAL_WEIGHT*ST2_W_BW-1:0] weight,
  output logic                                    weight_valid,
  output logic [CNT_W-1:0]                        load_cnt,
  output logic                                    err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_WEIGHT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic [TOTAL_WEIGHT*ST2_W_BW-1:0] rd_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      err_q      <= err_d;
    end
  end

  // start wins in every state; a handshake on the same cycle is dropped
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    if (start) begin
      state_d    = S_LOAD;
      load_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          if (s_valid) begin
            wr_en      = 1'b1;
            load_cnt_d = load_cnt_q + 1'b1;
            if (load_cnt_q == LAST_IDX) begin
              state_d = S_DONE;
              if (!s_last) err_d = 1'b1;
            end else if (s_last) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign s_ready      = (state_q == S_LOAD);
  assign weight_valid = (state_q == S_DONE);
  assign load_cnt     = load_cnt_q;
  assign err          = err_q;
  assign weight       = rd_bus;

  conv2_weight_regfile #(
    .DEPTH (TOTAL_WEIGHT),
    .DW    (ST2_W_BW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (load_cnt_q),
    .wr_data (s_data),
    .rd_bus  (rd_bus)
  );

endmodule

// File: tb/tb_conv2_weight_loader.sv
// Directed bench for conv2_weight_loader with a per-cycle reference model and literal spot checks.
module tb_conv2_weight_loader;

  localparam int unsigned N  = 225;
  localparam int unsigned BW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic signed [N*BW-1:0] weight;
  logic              weight_valid;
  logic [7:0]        load_cnt;
  logic              err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  conv2_weight_loader #(
    .ST2_Conv_CO (3),
    .ST2_Conv_CI (3),
    .KX          (5),
    .KY          (5),
    .ST2_W_BW    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .weight       (weight),
    .weight_valid (weight_valid),
    .load_cnt     (load_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Reference: "accepting" while a load is open, "complete" once all N words landed.
  logic [7:0]  m_mem [N];
  bit          m_accepting, m_complete, m_err;
  int unsigned m_cnt;

  initial begin
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_accepting = 0; m_complete = 0; m_err = 0; m_cnt = 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_accepting = 0; m_complete = 0; m_err = 0; m_cnt = 0;
    end else if (start) begin
      m_accepting = 1; m_complete = 0; m_err = 0; m_cnt = 0;
    end else if (m_accepting && s_valid) begin
      m_mem[m_cnt] = s_data;
      m_cnt++;
      if (m_cnt == N) begin
        m_accepting = 0;
        m_complete  = 1;
        if (!s_last) m_err = 1;
      end else if (s_last) begin
        m_accepting = 0;
        m_err       = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    int bad;
    chk("model_s_ready", 32'(s_ready), 32'(m_accepting));
    chk("model_weight_valid", 32'(weight_valid), 32'(m_complete));
    chk("model_load_cnt", 32'(load_cnt), m_cnt);
    chk("model_err", 32'(err), 32'(m_err));
    bad = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (weight[i*BW +: BW] !== m_mem[i]) bad = i;
    end
    n_checks++;
    if (bad < 0) n_pass++;
    else $display("FAIL model_weight entry %0d: got %0d expected %0d at %0t",
                  bad, weight[bad*BW +: BW], m_mem[bad], $time);
  end

  function automatic logic [7:0] val(input int unsigned kind, input int unsigned i);
    case (kind)
      0: return 8'(i);
      1: return 8'(255 - i);
      2: return 8'(i) ^ 8'h5A;
      3: return 8'(3 * i);
      default: return 8'd200;
    endcase
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int unsigned gap);
    bit hs;
    int unsigned n;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_data = d; s_last = last; s_valid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      hs = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!hs) begin
      n_checks++;
      $display("FAIL handshake_timeout: got no s_ready expected s_ready=1 at %0t", $time);
    end
  endtask

  task automatic load(input int unsigned nwords, input int unsigned last_at,
                      input int unsigned kind, input bit gaps);
    for (int unsigned i = 0; i < nwords; i++) begin
      send(val(kind, i), i == last_at, gaps ? $urandom_range(0, 3) : 0);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #20 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_weight_valid", 32'(weight_valid), 0);
    chk("reset_s_ready", 32'(s_ready), 0);
    chk("reset_load_cnt", 32'(load_cnt), 0);
    chk("reset_weight_zero", 32'(weight == '0), 1);

    // full load, continuous valid, s_last on the final word
    pulse_start();
    load(N, N - 1, 0, 0);
    chk("full_wv_rise", 32'(weight_valid), 1);
    chk("full_err", 32'(err), 0);
    chk("full_cnt", 32'(load_cnt), 225);
    chk("full_w0", 32'(weight[0*BW +: BW]), 0);
    chk("full_w100", 32'(weight[100*BW +: BW]), 100);
    chk("full_w224", 32'(weight[224*BW +: BW]), 224);
    repeat (3) @(posedge clk); #1;
    chk("done_hold_wv", 32'(weight_valid), 1);

    // same load with random gaps
    pulse_start();
    chk("restart_wv_low", 32'(weight_valid), 0);
    load(N, N - 1, 0, 1);
    chk("gap_wv", 32'(weight_valid), 1);
    chk("gap_w224", 32'(weight[224*BW +: BW]), 224);

    // early s_last on word 99
    pulse_start();
    load(100, 99, 1, 0);
    @(posedge clk); #1;
    chk("abort_err", 32'(err), 1);
    chk("abort_cnt", 32'(load_cnt), 100);
    chk("abort_idle_ready", 32'(s_ready), 0);
    chk("abort_wv", 32'(weight_valid), 0);
    chk("abort_w99", 32'(weight[99*BW +: BW]), 156);
    chk("abort_w100_old", 32'(weight[100*BW +: BW]), 100);

    // missing s_last on the final word
    pulse_start();
    load(N, 999, 2, 0);
    chk("nolast_err", 32'(err), 1);
    chk("nolast_wv", 32'(weight_valid), 1);
    chk("nolast_w224", 32'(weight[224*BW +: BW]), 186);

    // start coincident with the handshake of word 50
    pulse_start();
    load(50, 999, 3, 0);
    s_data = 8'hEE; s_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0;
    chk("collide_cnt", 32'(load_cnt), 0);
    chk("collide_w50_kept", 32'(weight[50*BW +: BW]), 104);
    chk("collide_w49", 32'(weight[49*BW +: BW]), 147);
    load(N, N - 1, 0, 0);
    chk("collide_reload_err", 32'(err), 0);
    chk("collide_reload_wv", 32'(weight_valid), 1);

    // asynchronous reset in the middle of word 120
    pulse_start();
    load(120, 999, 4, 0);
    s_data = 8'd200; s_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("areset_s_ready", 32'(s_ready), 0);
    chk("areset_wv", 32'(weight_valid), 0);
    chk("areset_cnt", 32'(load_cnt), 0);
    chk("areset_err", 32'(err), 0);
    chk("areset_weight", 32'(weight == '0), 1);
    #15 reset = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("post_reset_ready", 32'(s_ready), 0);
    chk("post_reset_wv", 32'(weight_valid), 0);
    s_valid = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/conv2_weight_loader.md
CONV2_WEIGHT_LOADER -- requirements
Module: conv2_weight_loader

Interface
REQ-001 SHALL have parameter ST2_Conv_CO, default 3, meaning conv2 output channels.
REQ-002 SHALL have parameter ST2_Conv_CI, default 3, meaning conv2 input channels.
REQ-003 SHALL have parameters KX and KY, default 5 each, meaning kernel width and height.
REQ-004 SHALL have parameter ST2_W_BW, default 8, meaning signed weight width; TOTAL_WEIGHT = CO*CI*KX*KY (225).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a full weight reload.
REQ-008 SHALL have port s_data, input, ST2_W_BW (signed), meaning one weight word of the incoming stream.
REQ-009 SHALL have ports s_valid (input, 1), s_last (input, 1) and s_ready (output, 1), meaning the stream handshake and the final-word marker.
REQ-010 SHALL have port weight, output, TOTAL_WEIGHT*ST2_W_BW (signed), meaning the flattened weight bus with weight i in bits [i*ST2_W_BW +: ST2_W_BW].
REQ-011 SHALL have port weight_valid, output, 1, meaning the bus holds a complete, consistent set of weights.
REQ-012 SHALL have port load_cnt, output, 8, meaning the number of words accepted in the current load.
REQ-013 SHALL have port err, output, 1, meaning a sticky framing error.

Function
REQ-014 SHALL implement states IDLE, LOAD and DONE.
REQ-015 SHALL, in IDLE, hold s_ready=0, and on start go to LOAD with load_cnt cleared to 0 and err cleared.
REQ-016 SHALL, in LOAD, hold s_ready=1, and on each cycle with s_valid&&s_ready write s_data to entry load_cnt and increment load_cnt.
REQ-017 SHALL, on the handshake of word TOTAL_WEIGHT-1, go to DONE and assert weight_valid=1 on the following cycle.
REQ-018 SHALL, if s_last arrives on a word before TOTAL_WEIGHT-1, write that word, set err=1, and return to IDLE with weight_valid=0.
REQ-019 SHALL, if s_last is absent on word TOTAL_WEIGHT-1, set err=1 and still go to DONE.
REQ-020 SHALL, in DONE, hold s_ready=0 and keep weight_valid=1 until the next start.
REQ-021 SHALL, on start in LOAD or DONE, restart the load: next state LOAD, load_cnt=0, err=0, weight_valid=0 on the next cycle. Start has priority over a same-cycle handshake, which is discarded.
REQ-022 SHALL leave stored entries unchanged on restart or abort, so old values remain on weight until overwritten.
REQ-023 SHALL drive weight from the registered storage with no combinational path from s_data to weight.
REQ-024 SHALL keep weight_valid=0 during the whole of any LOAD state.

Reset
REQ-025 SHALL, while reset=1, asynchronously force state=IDLE, all storage entries and weight to 0, and s_ready, weight_valid, load_cnt and err to 0.
REQ-026 SHALL, when reset is asserted mid-load, discard the partial load, so that a full start plus TOTAL_WEIGHT words is required to reach weight_valid=1.

Structure
REQ-027 SHALL take ST2_Conv_CO, ST2_Conv_CI, KX, KY and ST2_W_BW from the shared CNN defines header, with TOTAL_WEIGHT derived locally.
REQ-028 SHALL carry the state encoding as a local parameter and SHALL NOT add it to the shared header.
REQ-029 SHALL use a single optional sub-module, conv2_weight_regfile (write port plus flattened read bus); the FSM and counter SHALL remain in the top module.
REQ-030 SHALL produce a weight bus bit-identical to the existing conv2 weight bus format, so that the module is a drop-in replacement for it.

Verification
REQ-031 SHALL pass: start, then 225 words with value i (mod 256), s_valid always high, s_last on word 224 -> weight_valid rises on the cycle after word 224, weight[i*8+:8]==i, err=0, load_cnt=225.
REQ-032 SHALL pass: the same load with random s_valid gaps -> identical final bus, and weight_valid stays 0 until the final handshake.
REQ-033 SHALL pass: s_last on word 99 -> err=1, state IDLE, weight_valid=0, load_cnt=100, entries 0..99 updated.
REQ-034 SHALL pass: no s_last on word 224 -> err=1 and weight_valid=1.
REQ-035 SHALL pass: start pulsed on the same cycle as the handshake of word 50 -> that word is not written, load_cnt=0, and a subsequent full load completes with err=0.
REQ-036 SHALL pass: reset asserted asynchronously at word 120 -> all outputs are 0 immediately, and with no new start s_ready stays 0.
